// File: rtl/riscv_decode_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_decode_cycle
//  Brief    : RV32I decode (ID) stage. Decodes the instruction, reads two
//             operands from a 32x32 register file, sign-extends the
//             immediate and registers everything into the ID/EX register.
//             The writeback port updates the register file.
//  Config   : REGFILE_BYPASS_EN - when defined, a same-cycle writeback to a
//             source register is forwarded into RD1_E/RD2_E.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_decode_cycle (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrD,
   input  logic [31:0] PCD,
   input  logic [31:0] PCPlus4D,
   input  logic        RegWriteW,
   input  logic [4:0]  RDW,
   input  logic [31:0] ResultW,
   output logic        RegWriteE,
   output logic        ALUSrcE,
   output logic        MemWriteE,
   output logic        ResultSrcE,
   output logic        BranchE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1_E,
   output logic [31:0] RD2_E,
   output logic [31:0] Imm_Ext_E,
   output logic [4:0]  RS1_E,
   output logic [4:0]  RS2_E,
   output logic [4:0]  RD_E,
   output logic [31:0] PCE,
   output logic [31:0] PCPlus4E
);

   localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
   localparam logic [6:0] c_OP_STORE = 7'b0100011;
   localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
   localparam logic [6:0] c_OP_BRNCH = 7'b1100011;
   localparam logic [6:0] c_OP_IALU  = 7'b0010011;

   // Raw instruction fields
   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic        w_funct7_5;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [4:0]  w_rd;

   assign w_opcode   = InstrD[6:0];
   assign w_rd       = InstrD[11:7];
   assign w_funct3   = InstrD[14:12];
   assign w_rs1      = InstrD[19:15];
   assign w_rs2      = InstrD[24:20];
   assign w_funct7_5 = InstrD[30];

   // Decoded control
   logic        w_reg_write;
   logic [1:0]  w_imm_src;
   logic        w_alu_src;
   logic        w_mem_write;
   logic        w_result_src;
   logic        w_branch;
   logic [1:0]  w_alu_op;
   logic [2:0]  w_alu_ctrl;
   logic [31:0] w_imm_ext;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;

   // Register file storage; entry 0 is held at zero and never written
   logic [31:0] r_regs [32];

   // Pipeline registers
   logic        r_reg_write;
   logic        r_alu_src;
   logic        r_mem_write;
   logic        r_result_src;
   logic        r_branch;
   logic [2:0]  r_alu_ctrl;
   logic [31:0] r_rd1;
   logic [31:0] r_rd2;
   logic [31:0] r_imm_ext;
   logic [4:0]  r_rs1;
   logic [4:0]  r_rs2;
   logic [4:0]  r_rd;
   logic [31:0] r_pc;
   logic [31:0] r_pc_plus4;

   // Main decoder: opcode to control signals; unknown opcodes decode as a bubble
   always_comb begin
      w_reg_write  = 1'b0;
      w_imm_src    = 2'b00;
      w_alu_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_result_src = 1'b0;
      w_branch     = 1'b0;
      w_alu_op     = 2'b00;
      case (w_opcode)
         c_OP_LOAD: begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_result_src = 1'b1;
         end
         c_OP_STORE: begin
            w_imm_src    = 2'b01;
            w_alu_src    = 1'b1;
            w_mem_write  = 1'b1;
         end
         c_OP_RTYPE: begin
            w_reg_write  = 1'b1;
            w_alu_op     = 2'b10;
         end
         c_OP_BRNCH: begin
            w_imm_src    = 2'b10;
            w_branch     = 1'b1;
            w_alu_op     = 2'b01;
         end
         c_OP_IALU: begin
            w_reg_write  = 1'b1;
            w_alu_src    = 1'b1;
            w_alu_op     = 2'b10;
         end
         default: ;
      endcase
   end

   // ALU decoder: only R-type with funct7[5] set selects subtract for funct3 000
   always_comb begin
      w_alu_ctrl = 3'b000;
      case (w_alu_op)
         2'b01: w_alu_ctrl = 3'b001;
         2'b10: begin
            case (w_funct3)
               3'b000:  w_alu_ctrl = ({w_opcode[5], w_funct7_5} == 2'b11) ? 3'b001 : 3'b000;
               3'b010:  w_alu_ctrl = 3'b101;
               3'b110:  w_alu_ctrl = 3'b011;
               3'b111:  w_alu_ctrl = 3'b010;
               default: w_alu_ctrl = 3'b000;
            endcase
         end
         default: w_alu_ctrl = 3'b000;
      endcase
   end

   // Immediate generation by format
   always_comb begin
      w_imm_ext = 32'd0;
      case (w_imm_src)
         2'b00:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
         2'b01:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         2'b10:   w_imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
         default: w_imm_ext = 32'd0;
      endcase
   end

   // Register file read ports; x0 is forced to zero regardless of storage
   always_comb begin
      w_rd1 = r_regs[w_rs1];
      w_rd2 = r_regs[w_rs2];
`ifdef REGFILE_BYPASS_EN
      if (RegWriteW && (RDW == w_rs1)) w_rd1 = ResultW;
      if (RegWriteW && (RDW == w_rs2)) w_rd2 = ResultW;
`endif
      if (w_rs1 == 5'd0) w_rd1 = 32'd0;
      if (w_rs2 == 5'd0) w_rd2 = 32'd0;
   end

   // Register file write port; reset clears all entries and overrides writes
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
      end else if (RegWriteW && (RDW != 5'd0)) begin
         r_regs[RDW] <= ResultW;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reg_write  <= 1'b0;
         r_alu_src    <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= 1'b0;
         r_branch     <= 1'b0;
         r_alu_ctrl   <= 3'b000;
         r_rd1        <= 32'd0;
         r_rd2        <= 32'd0;
         r_imm_ext    <= 32'd0;
         r_rs1        <= 5'd0;
         r_rs2        <= 5'd0;
         r_rd         <= 5'd0;
         r_pc         <= 32'd0;
         r_pc_plus4   <= 32'd0;
      end else begin
         r_reg_write  <= w_reg_write;
         r_alu_src    <= w_alu_src;
         r_mem_write  <= w_mem_write;
         r_result_src <= w_result_src;
         r_branch     <= w_branch;
         r_alu_ctrl   <= w_alu_ctrl;
         r_rd1        <= w_rd1;
         r_rd2        <= w_rd2;
         r_imm_ext    <= w_imm_ext;
         r_rs1        <= w_rs1;
         r_rs2        <= w_rs2;
         r_rd         <= w_rd;
         r_pc         <= PCD;
         r_pc_plus4   <= PCPlus4D;
      end
   end

   assign RegWriteE   = r_reg_write;
   assign ALUSrcE     = r_alu_src;
   assign MemWriteE   = r_mem_write;
   assign ResultSrcE  = r_result_src;
   assign BranchE     = r_branch;
   assign ALUControlE = r_alu_ctrl;
   assign RD1_E       = r_rd1;
   assign RD2_E       = r_rd2;
   assign Imm_Ext_E   = r_imm_ext;
   assign RS1_E       = r_rs1;
   assign RS2_E       = r_rs2;
   assign RD_E        = r_rd;
   assign PCE         = r_pc;
   assign PCPlus4E    = r_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_decode_cycle
//  Brief    : Scoreboard bench for riscv_decode_cycle. Directed instructions
//             followed by random ones, checked against an instruction-level
//             reference model. Honours REGFILE_BYPASS_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_decode_cycle;

   typedef struct packed {
      logic        imm_dc;     // immediate is a don't-care (R-type)
      logic        rw, as, mw, rs, br;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] pc, pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
   logic        RegWriteW = 1'b0;
   logic [4:0]  RDW = '0;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
   logic [4:0]  RS1_E, RS2_E, RD_E;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb_q[$];
   logic [31:0] m_regs [32];

   riscv_decode_cycle dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
      .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
      .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
   );

   always #5 clk = ~clk;

   // Architectural register read as seen by an instruction in decode
   function automatic logic [31:0] reg_read(input logic [4:0] r, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
      if (we && wa == r) return wd;
`endif
      return m_regs[r];
   endfunction

   // Operation for arithmetic instructions, named by mnemonic
   function automatic logic [2:0] alu_op_of(input logic [2:0] f3, input logic is_sub);
      case (f3)
         3'd0:    return is_sub ? 3'b001 : 3'b000;  // sub / add
         3'd2:    return 3'b101;                     // slt
         3'd6:    return 3'b011;                     // or
         3'd7:    return 3'b010;                     // and
         default: return 3'b000;
      endcase
   endfunction

   // Instruction-level reference model
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] pc4,
                                  input logic we, input logic [4:0] wa, input logic [31:0] wd);
      exp_t        e;
      logic [11:0] i_imm, s_imm;
      logic [12:0] b_imm;
      e       = '0;
      i_imm   = i[31:20];
      s_imm   = {i[31:25], i[11:7]};
      b_imm   = {i[31], i[7], i[30:25], i[11:8], 1'b0};
      e.rs1   = i[19:15];
      e.rs2   = i[24:20];
      e.rd    = i[11:7];
      e.pc    = pc;
      e.pc4   = pc4;
      e.rd1   = reg_read(i[19:15], we, wa, wd);
      e.rd2   = reg_read(i[24:20], we, wa, wd);
      e.imm   = {{20{i_imm[11]}}, i_imm};
      case (i[6:0])
         7'h03: begin e.rw = 1; e.as = 1; e.rs = 1; end                             // lw
         7'h23: begin e.as = 1; e.mw = 1; e.imm = {{20{s_imm[11]}}, s_imm}; end    // sw
         7'h33: begin e.rw = 1; e.imm_dc = 1; e.alu = alu_op_of(i[14:12], i[30]); end
         7'h63: begin e.br = 1; e.alu = 3'b001; e.imm = {{19{b_imm[12]}}, b_imm}; end
         7'h13: begin e.rw = 1; e.as = 1; e.alu = alu_op_of(i[14:12], 1'b0); end
         default: ;
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus and record the expected ID/EX contents
   task automatic drive(input logic r, input logic [31:0] instr, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
      exp_t e;
      @(negedge clk);
      rst = r; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
      RegWriteW = we; RDW = wa; ResultW = wd;
      if (r) begin
         e = '0;
         for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      end else begin
         e = model(instr, pc, pc + 32'd4, we, wa, wd);
         if (we && wa != 5'd0) m_regs[wa] = wd;
      end
      sb_q.push_back(e);
      @(posedge clk);
   endtask

   // Monitor: the pipeline register presents a result one cycle after issue
   initial begin
      exp_t m;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            m = sb_q.pop_front();
            chk("RegWriteE",   {31'd0, RegWriteE},  {31'd0, m.rw});
            chk("ALUSrcE",     {31'd0, ALUSrcE},    {31'd0, m.as});
            chk("MemWriteE",   {31'd0, MemWriteE},  {31'd0, m.mw});
            chk("ResultSrcE",  {31'd0, ResultSrcE}, {31'd0, m.rs});
            chk("BranchE",     {31'd0, BranchE},    {31'd0, m.br});
            chk("ALUControlE", {29'd0, ALUControlE}, {29'd0, m.alu});
            chk("RD1_E",       RD1_E, m.rd1);
            chk("RD2_E",       RD2_E, m.rd2);
            if (!m.imm_dc) chk("Imm_Ext_E", Imm_Ext_E, m.imm);
            chk("RS1_E",       {27'd0, RS1_E}, {27'd0, m.rs1});
            chk("RS2_E",       {27'd0, RS2_E}, {27'd0, m.rs2});
            chk("RD_E",        {27'd0, RD_E},  {27'd0, m.rd});
            chk("PCE",         PCE, m.pc);
            chk("PCPlus4E",    PCPlus4E, m.pc4);
         end
      end
   end

   initial begin
      logic [31:0] ins;
      logic [6:0]  ops [6];
      logic [2:0]  f3s [5];
      logic [31:0] pc;
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
      ops[3] = 7'h63; ops[4] = 7'h13; ops[5] = 7'h00;
      f3s[0] = 3'd0; f3s[1] = 3'd2; f3s[2] = 3'd6; f3s[3] = 3'd7; f3s[4] = 3'd0;

      // Reset, with a concurrent write that reset must suppress
      drive(1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 5'd3, 32'hDEAD_BEEF);
      drive(1'b1, 32'h00100093, 32'h0,    1'b0, 5'd0, 32'h0);
      // Directed sequence
      drive(1'b0, 32'h00100093, 32'h0,  1'b0, 5'd0, 32'h0);          // addi x1,x0,1
      drive(1'b0, 32'h003181b3, 32'h4,  1'b0, 5'd0, 32'h0);          // add x3,x3,x3 -> reads 0
      drive(1'b0, 32'h00000000, 32'h8,  1'b1, 5'd1, 32'h0000_000A);  // W: x1 = 0xA
      drive(1'b0, 32'h00208113, 32'h4,  1'b0, 5'd0, 32'h0);          // addi x2,x1,2
      drive(1'b0, 32'h00208113, 32'h4,  1'b1, 5'd1, 32'h0000_0077);  // same-cycle write
      drive(1'b0, 32'h00208113, 32'h4,  1'b1, 5'd2, 32'h0000_0022);  // x2 = 0x22
      drive(1'b0, 32'h40208033, 32'hC,  1'b0, 5'd0, 32'h0);          // sub
      drive(1'b0, 32'h0020f033, 32'h10, 1'b0, 5'd0, 32'h0);          // and
      drive(1'b0, 32'h0020a033, 32'h14, 1'b0, 5'd0, 32'h0);          // slt
      drive(1'b0, 32'h0020e033, 32'h18, 1'b0, 5'd0, 32'h0);          // or
      drive(1'b0, 32'hFE112E23, 32'h1C, 1'b0, 5'd0, 32'h0);          // sw x1,-4(x2)
      drive(1'b0, 32'hFFC12083, 32'h20, 1'b0, 5'd0, 32'h0);          // lw
      drive(1'b0, 32'hFE000EE3, 32'h24, 1'b1, 5'd0, 32'h0000_0055);  // beq, write x0
      drive(1'b0, 32'h000001b3, 32'h28, 1'b0, 5'd0, 32'h0);          // add x3,x0,x0
      drive(1'b0, 32'h4020_8093, 32'h2C, 1'b0, 5'd0, 32'h0);         // addi with bit30 set -> add

      // Randomized traffic
      pc = 32'h100;
      for (int n = 0; n < 400; n++) begin
         logic        we;
         logic [4:0]  wa;
         ins       = $urandom;
         ins[6:0]  = (n % 7 == 6) ? 7'($urandom) : ops[$urandom_range(0, 5)];
         if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
            ins[14:12] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 4)];
            if (ins[6:0] == 7'h33) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
         end
         we = 1'($urandom_range(0, 1));
         wa = 5'($urandom);
         if ($urandom_range(0, 3) == 0) ins[19:15] = wa;
         if ($urandom_range(0, 3) == 0) ins[24:20] = wa;
         drive((n == 200) ? 1'b1 : 1'b0, ins, pc, we, wa, $urandom);
         pc = pc + 32'd4;
      end
      drive(1'b0, 32'h0, pc, 1'b0, 5'd0, 32'h0);

      // Drain the scoreboard within a bounded number of cycles
      for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
      repeat (2) @(posedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
